rec_gate_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one gated single-bit pass path
//  (s = inh ? 0 : din) among N requesters.

---
 rtl/rec_gate_arbiter.sv | 110 +++++++++++
 tb/tb_rec_gate_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rec_gate_arbiter.sv
// rec_gate_arbiter: round-robin arbiter sharing one registered, inhibit-gated single-bit pass path among N requesters
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   req_i   per-requester request level, held until granted
//   din_i   per-requester data bit; only the owner's bit reaches the path
//   inh_i   inhibit; forces the path output low
//   lock_i  per-requester grant extension (present only with REC_ARB_LOCK_EN)
//   gnt_o   one-hot grant, zero when no owner
//   s_o     registered gated path output
//   busy_o  high while a grant is active
// Optional feature macro: REC_ARB_LOCK_EN
module rec_gate_arbiter #(
    parameter int N    = 4,
    parameter int HOLD = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] din_i,
    input  logic         inh_i,
`ifdef REC_ARB_LOCK_EN
    input  logic [N-1:0] lock_i,
`endif
    output logic [N-1:0] gnt_o,
    output logic         s_o,
    output logic         busy_o
);
    localparam int PW = $clog2(N) > 0 ? $clog2(N) : 1;
    localparam int CW = $clog2(HOLD) > 0 ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CMAX = CW'(HOLD - 1);
    localparam logic [PW-1:0] PMAX = PW'(N - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d;
    logic [PW-1:0] pick;
    logic          lock_own;
    logic          rel;

`ifdef REC_ARB_LOCK_EN
    assign lock_own = lock_i[owner_q];
`else
    assign lock_own = 1'b0;
`endif

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx  = '0;
        pick = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (req_i[idx]) pick = idx;
        end
    end

    assign rel = !req_i[owner_q] || (!lock_own && cnt_q == CMAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = '0;
        s_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    owner_d = pick;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d = GAP;
                    ptr_d   = (owner_q == PMAX) ? '0 : owner_q + 1'b1;
                end else begin
                    s_d   = inh_i ? 1'b0 : din_i[owner_q];
                    // Saturates so a locked grant never wraps the counter.
                    cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

    assign gnt_o  = (state_q == GRANT) ? N'(1) << owner_q : '0;
    assign busy_o = (state_q == GRANT);
    assign s_o    = s_q;
endmodule

// File: tb/tb_rec_gate_arbiter.sv
// tb_rec_gate_arbiter: directed self-checking bench for rec_gate_arbiter (N=4, HOLD=4)
module tb_rec_gate_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic       inh;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       s;
    logic       busy;
    int         tests = 0;
    int         fails = 0;

    rec_gate_arbiter #(.N(4), .HOLD(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .din_i  (din),
        .inh_i  (inh),
`ifdef REC_ARB_LOCK_EN
        .lock_i (lock),
`endif
        .gnt_o  (gnt),
        .s_o    (s),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rot [5];
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req = '0; din = '0; inh = 1'b0; lock = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_s", {3'b0, s}, 4'b0000);
        chk("rst_busy", {3'b0, busy}, 4'b0000);
        repeat (3) begin
            step();
            chk("idle_gnt", gnt, 4'b0000);
            chk("idle_busy", {3'b0, busy}, 4'b0000);
        end

        // single requester, HOLD limit, gap and re-grant
        req = 4'b0001; din = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t2_gnt", gnt, 4'b0001);
            chk("t2_s", {3'b0, s}, c == 0 ? 4'b0000 : 4'b0001);
            chk("t2_busy", {3'b0, busy}, 4'b0001);
        end
        step();
        chk("t2_rel_gnt", gnt, 4'b0000);
        chk("t2_rel_s", {3'b0, s}, 4'b0000);
        chk("t2_rel_busy", {3'b0, busy}, 4'b0000);
        step();
        chk("t2_idle_gnt", gnt, 4'b0000);
        step();
        chk("t2_regnt", gnt, 4'b0001);
        // early release by dropping req
        req = 4'b0000;
        step();
        chk("t2_early_rel", gnt, 4'b0000);
        chk("t2_early_s", {3'b0, s}, 4'b0000);
        step();
        step();
        chk("t2_stay_idle", gnt, 4'b0000);

        // all request: rotation with wrap
        pulse_rst();
        din = 4'b0000;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t3_first", gnt, rot[g]);
            repeat (3) step();
            chk("t3_last", gnt, rot[g]);
            chk("t3_s", {3'b0, s}, 4'b0000);
            step();
            chk("t3_rel", gnt, 4'b0000);
            step();
            chk("t3_gap", gnt, 4'b0000);
        end
        req = 4'b0000;

        // inhibit toggling on owner 1
        pulse_rst();
        req = 4'b0010; din = 4'b0010; inh = 1'b0;
        step();
        chk("t4_gnt0", gnt, 4'b0010);
        chk("t4_s0", {3'b0, s}, 4'b0000);
        step();
        chk("t4_s1", {3'b0, s}, 4'b0001);
        inh = 1'b1;
        step();
        chk("t4_s_inh", {3'b0, s}, 4'b0000);
        chk("t4_gnt_inh", gnt, 4'b0010);
        inh = 1'b0;
        step();
        chk("t4_s_uninh", {3'b0, s}, 4'b0001);
        chk("t4_gnt3", gnt, 4'b0010);
        step();
        chk("t4_rel", gnt, 4'b0000);
        chk("t4_rel_s", {3'b0, s}, 4'b0000);
        req = 4'b0000;
        step();
        step();

        // asynchronous reset mid-grant
        pulse_rst();
        req = 4'b0001; din = 4'b0001;
        step();
        step();
        chk("t5_pre_s", {3'b0, s}, 4'b0001);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_gnt", gnt, 4'b0000);
        chk("t5_async_s", {3'b0, s}, 4'b0000);
        chk("t5_async_busy", {3'b0, busy}, 4'b0000);
        rst = 1'b0;
        req = 4'b1000;
        step();
        chk("t5_gnt3", gnt, 4'b1000);
        req = 4'b0000;
        step();
        chk("t5_rel", gnt, 4'b0000);
        step();
        step();

`ifdef REC_ARB_LOCK_EN
        pulse_rst();
        din = 4'b0000;
        req = 4'b0011; lock = 4'b0001;
        step();
        chk("t6_gnt_first", gnt, 4'b0001);
        repeat (9) step();
        chk("t6_gnt_held", gnt, 4'b0001);
        req = 4'b0010;
        step();
        chk("t6_rel", gnt, 4'b0000);
        step();
        chk("t6_gap", gnt, 4'b0000);
        step();
        chk("t6_next", gnt, 4'b0010);
        req = 4'b0000; lock = 4'b0000;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
